// File: rtl/click_judge_pkg.sv
// Shared types and widths for the click judge.
package click_judge_pkg;
  localparam int COORD_W = 11;
  localparam int CMP_W   = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, ARMED, JUDGE} state_e;
endpackage

// File: rtl/rising_edge.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module rising_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= in;
  end

  assign pulse = in & ~prev_q;
endmodule

// File: rtl/click_judge.sv
// Judges whether a mouse click lands inside the armed target square within
// the allowed window; emits one hit or miss pulse per armed square.
module click_judge
  import click_judge_pkg::*;
#(
  parameter int SQUARE_SIZE    = 20,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               square_valid,
  input  logic [COORD_W-1:0] square_x0,
  input  logic [COORD_W-1:0] square_y0,
  input  logic               mouse_click,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  output logic               hit,
  output logic               miss,
  output logic               armed
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CMP_W-1:0] SZ   = CMP_W'(SQUARE_SIZE);

  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [COORD_W-1:0] x0_q, y0_q;
  logic               hit_q, miss_q;
  logic               click_edge;
  logic               inside_d;

  rising_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (mouse_click),
    .pulse (click_edge)
  );

  // One extra bit so x0+SQUARE_SIZE near the screen edge cannot wrap.
  logic [CMP_W-1:0] mx_w, my_w, x0_w, y0_w;
  assign mx_w = CMP_W'(mouse_x);
  assign my_w = CMP_W'(mouse_y);
  assign x0_w = CMP_W'(x0_q);
  assign y0_w = CMP_W'(y0_q);

  assign inside_d = (mx_w >= x0_w) && (mx_w < x0_w + SZ) &&
                    (my_w >= y0_w) && (my_w < y0_w + SZ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      // A new square always re-arms, discarding any simultaneous click.
      if (square_valid) begin
        x0_q    <= square_x0;
        y0_q    <= square_y0;
        timer_q <= '0;
        state_q <= ARMED;
      end else begin
        case (state_q)
          ARMED: begin
            if (click_edge) begin
              state_q <= JUDGE;
              hit_q   <= inside_d;
              miss_q  <= ~inside_d;
            end else if (timer_q == TMAX) begin
              state_q <= JUDGE;
              miss_q  <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          JUDGE:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hit   = hit_q;
  assign miss  = miss_q;
  assign armed = (state_q == ARMED);
endmodule
